// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped timer: register offsets, CTRL bit
// positions and the data-port access-size encodings used by the RAM model too.
package timer_pkg;

   localparam logic [4:0] TMR_CTRL     = 5'h00;
   localparam logic [4:0] TMR_COUNT    = 5'h04;
   localparam logic [4:0] TMR_COMPARE  = 5'h08;
   localparam logic [4:0] TMR_STATUS   = 5'h0C;
   localparam logic [4:0] TMR_PRESCALE = 5'h10;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IE   = 2;

   localparam logic [1:0] MASK_WORD = 2'b00;
   localparam logic [1:0] MASK_HALF = 2'b01;
   localparam logic [1:0] MASK_BYTE = 2'b10;

   // Picks the half/byte addressed by byte_sel and extends it; 2'b11 acts as word.
   function automatic logic [31:0] extend_field(input logic [31:0] word,
                                                input logic [1:0]  byte_sel,
                                                input logic [1:0]  mask,
                                                input logic        signed_ext);
      logic [15:0] half_val;
      logic [7:0]  byte_val;
      logic [31:0] result;
      half_val = byte_sel[1] ? word[31:16] : word[15:0];
      case (byte_sel)
         2'd0:    byte_val = word[7:0];
         2'd1:    byte_val = word[15:8];
         2'd2:    byte_val = word[23:16];
         default: byte_val = word[31:24];
      endcase
      case (mask)
         MASK_HALF: result = {{16{signed_ext & half_val[15]}}, half_val};
         MASK_BYTE: result = {{24{signed_ext & byte_val[7]}}, byte_val};
         default:   result = word;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// CPU data-memory port as seen by the timer: the CPU side is the master,
// the timer responds with combinational rdata and an address-hit flag.
interface mmio_timer_if;
   logic        we;
   logic [31:0] addr;
   logic [1:0]  mask;
   logic        signed_ext;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;

   modport master (output we, addr, mask, signed_ext, wdata,
                   input  rdata, hit);

   modport slave  (input  we, addr, mask, signed_ext, wdata,
                   output rdata, hit);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Divides the clock: tick is high for one cycle every limit+1 enabled cycles.
// Held at zero while disabled or when software reprograms the timer.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] limit,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] phase;

   assign tick = en && (phase == limit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (clr || !en || tick) begin
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: register window decode, prescaled up-counter
// with compare/auto-reload, sticky MATCH status and a level interrupt.
module mmio_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
   parameter int          PRESCALE_W = 16
) (
   input  logic         clk,
   input  logic         reset,
   mmio_timer_if.slave  bus,
   output logic         irq
);

   logic [31:0]           offset;
   logic                  hit;
   logic [4:0]            reg_off;
   logic                  wr_en;
   logic                  wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;

   logic [2:0]            ctrl;
   logic [31:0]           count;
   logic [31:0]           compare;
   logic                  match;
   logic [PRESCALE_W-1:0] prescale;

   logic                  tick;
   logic                  match_now;
   logic                  prescale_clr;
   logic [31:0]           reg_word;

   // Subtracting the base keeps the window check correct for any word-aligned base.
   assign offset  = bus.addr - BASE_ADDR;
   assign hit     = (offset[31:5] == 27'd0);
   assign reg_off = {offset[4:2], 2'b00};
   assign wr_en   = bus.we && hit && (bus.mask == MASK_WORD || bus.mask == 2'b11);

   assign wr_ctrl     = wr_en && (reg_off == TMR_CTRL);
   assign wr_count    = wr_en && (reg_off == TMR_COUNT);
   assign wr_compare  = wr_en && (reg_off == TMR_COMPARE);
   assign wr_status   = wr_en && (reg_off == TMR_STATUS);
   assign wr_prescale = wr_en && (reg_off == TMR_PRESCALE);

   assign prescale_clr = wr_prescale || (wr_ctrl && !bus.wdata[CTRL_EN]);
   assign match_now    = tick && !wr_count && (count == compare);

   timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (ctrl[CTRL_EN]),
      .clr   (prescale_clr),
      .limit (prescale),
      .tick  (tick)
   );

   // A software COUNT write overrides the tick; a new match beats write-1-clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl     <= '0;
         count    <= '0;
         compare  <= 32'hFFFF_FFFF;
         match    <= 1'b0;
         prescale <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl <= bus.wdata[2:0];
         end
         if (wr_compare) begin
            compare <= bus.wdata;
         end
         if (wr_prescale) begin
            prescale <= bus.wdata[PRESCALE_W-1:0];
         end
         if (wr_count) begin
            count <= bus.wdata;
         end else if (tick) begin
            count <= (match_now && ctrl[CTRL_AUTO]) ? 32'd0 : count + 32'd1;
         end
         if (match_now) begin
            match <= 1'b1;
         end else if (wr_status && bus.wdata[0]) begin
            match <= 1'b0;
         end
      end
   end

   always_comb begin
      reg_word = '0;
      case (reg_off)
         TMR_CTRL:     reg_word = {29'd0, ctrl};
         TMR_COUNT:    reg_word = count;
         TMR_COMPARE:  reg_word = compare;
         TMR_STATUS:   reg_word = {31'd0, match};
         TMR_PRESCALE: reg_word = 32'(prescale);
         default:      reg_word = '0;
      endcase
   end

   assign bus.rdata = hit ? extend_field(reg_word, offset[1:0], bus.mask, bus.signed_ext) : 32'd0;
   assign bus.hit   = hit;
   assign irq       = match & ctrl[CTRL_IE];

endmodule

// File: tb/tb_mmio_timer.sv
// Directed and randomized checks of mmio_timer against an arithmetic
// reference model of the register map, tick schedule and interrupt.
module tb_mmio_timer;
   import timer_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_8000;

   logic clk = 1'b0;
   logic reset;
   logic irq;
   int   checks = 0;
   int   errors = 0;

   mmio_timer_if bus ();

   mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   logic [2:0]  m_ctrl;
   logic [31:0] m_count;
   logic [31:0] m_compare;
   logic        m_match;
   logic [31:0] m_prescale;
   int unsigned m_phase;

   function automatic bit model_hit(input logic [31:0] a);
      return (a >= BASE) && (a <= BASE + 32'd31);
   endfunction

   function automatic logic [31:0] model_word(input int off);
      case (off)
         0:       return {29'd0, m_ctrl};
         4:       return m_count;
         8:       return m_compare;
         12:      return {31'd0, m_match};
         16:      return m_prescale;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] m, input logic s);
      logic [31:0] rel;
      logic [31:0] w;
      logic [31:0] f;
      if (!model_hit(a)) return 32'd0;
      rel = a - BASE;
      w   = model_word(int'(rel) & ~3);
      if (m == MASK_HALF) begin
         f = (w >> (int'(rel[1]) * 16)) & 32'h0000_FFFF;
         if (s && f[15]) f = f | 32'hFFFF_0000;
         return f;
      end
      if (m == MASK_BYTE) begin
         f = (w >> (int'(rel[1:0]) * 8)) & 32'h0000_00FF;
         if (s && f[7]) f = f | 32'hFFFF_FF00;
         return f;
      end
      return w;
   endfunction

   // Reference model: ticks fall where the enabled-cycle count hits P mod (P+1).
   always @(posedge clk or posedge reset) begin : model_update
      bit wr;
      int off;
      bit tk;
      bit matched;
      if (reset) begin
         m_ctrl     = 3'd0;
         m_count    = 32'd0;
         m_compare  = 32'hFFFF_FFFF;
         m_match    = 1'b0;
         m_prescale = 32'd0;
         m_phase    = 0;
      end else begin
         wr      = bus.we && model_hit(bus.addr) && (bus.mask == 2'b00 || bus.mask == 2'b11);
         off     = int'(bus.addr - BASE) & ~3;
         tk      = m_ctrl[0] && ((m_phase % (m_prescale + 32'd1)) == m_prescale);
         matched = tk && !(wr && off == 4) && (m_count == m_compare);
         if (wr && off == 4) m_count = bus.wdata;
         else if (tk) m_count = (matched && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
         if (matched) m_match = 1'b1;
         else if (wr && off == 12 && bus.wdata[0]) m_match = 1'b0;
         if (!m_ctrl[0] || (wr && off == 16) || (wr && off == 0 && !bus.wdata[0])) m_phase = 0;
         else m_phase = m_phase + 1;
         if (wr && off == 0)  m_ctrl = bus.wdata[2:0];
         if (wr && off == 8)  m_compare = bus.wdata;
         if (wr && off == 16) m_prescale = {16'd0, bus.wdata[15:0]};
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [1:0] m,
                                 input logic s, input logic [31:0] d);
      bus.we         = w;
      bus.addr       = a;
      bus.mask       = m;
      bus.signed_ext = s;
      bus.wdata      = d;
   endtask

   task automatic write_reg(input logic [4:0] off, input logic [31:0] data);
      apply_stimulus(1'b1, BASE + 32'(off), MASK_WORD, 1'b0, data);
      @(negedge clk);
      bus.we = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.we = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic read_check(input string tag, input logic [4:0] off, input logic [1:0] m,
                             input logic s, input logic [31:0] expected);
      apply_stimulus(1'b0, BASE + 32'(off), m, s, 32'd0);
      #1;
      check_output(tag, bus.rdata, expected);
   endtask

   task automatic do_reset();
      bus.we = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [4:0]  off;
      int          r;

      reset = 1'b1;
      apply_stimulus(1'b0, BASE, MASK_WORD, 1'b0, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      $display("[TB] reset values");
      read_check("rst_ctrl",     TMR_CTRL,     MASK_WORD, 1'b0, 32'd0);
      read_check("rst_count",    TMR_COUNT,    MASK_WORD, 1'b0, 32'd0);
      read_check("rst_compare",  TMR_COMPARE,  MASK_WORD, 1'b0, 32'hFFFF_FFFF);
      read_check("rst_status",   TMR_STATUS,   MASK_WORD, 1'b0, 32'd0);
      read_check("rst_prescale", TMR_PRESCALE, MASK_WORD, 1'b0, 32'd0);
      check_output("rst_irq", {31'd0, irq}, 32'd0);

      $display("[TB] compare match with prescale 0");
      write_reg(TMR_PRESCALE, 32'd0);
      write_reg(TMR_COMPARE, 32'd5);
      write_reg(TMR_CTRL, 32'd5);
      idle(5);
      read_check("m_count5",  TMR_COUNT,  MASK_WORD, 1'b0, 32'd5);
      read_check("m_status0", TMR_STATUS, MASK_WORD, 1'b0, 32'd0);
      check_output("m_irq0", {31'd0, irq}, 32'd0);
      idle(1);
      read_check("m_status1", TMR_STATUS, MASK_WORD, 1'b0, 32'd1);
      check_output("m_irq1", {31'd0, irq}, 32'd1);
      read_check("m_count6",  TMR_COUNT,  MASK_WORD, 1'b0, 32'd6);

      $display("[TB] auto reload with prescale 3");
      do_reset();
      write_reg(TMR_PRESCALE, 32'd3);
      write_reg(TMR_COMPARE, 32'd2);
      write_reg(TMR_CTRL, 32'd7);
      for (int i = 0; i < 16; i++) begin
         read_check("ar_count",  TMR_COUNT,  MASK_WORD, 1'b0, 32'((i / 4) % 3));
         read_check("ar_status", TMR_STATUS, MASK_WORD, 1'b0, (i >= 12) ? 32'd1 : 32'd0);
         idle(1);
      end

      $display("[TB] wrap and clear racing a match");
      do_reset();
      write_reg(TMR_COUNT, 32'hFFFF_FFFE);
      write_reg(TMR_COMPARE, 32'd0);
      write_reg(TMR_CTRL, 32'd1);
      read_check("wr_count_fe", TMR_COUNT, MASK_WORD, 1'b0, 32'hFFFF_FFFE);
      idle(1);
      read_check("wr_count_ff", TMR_COUNT, MASK_WORD, 1'b0, 32'hFFFF_FFFF);
      idle(1);
      read_check("wr_count_0",  TMR_COUNT,  MASK_WORD, 1'b0, 32'd0);
      read_check("wr_status0",  TMR_STATUS, MASK_WORD, 1'b0, 32'd0);
      write_reg(TMR_STATUS, 32'd1);
      read_check("wr_status_kept", TMR_STATUS, MASK_WORD, 1'b0, 32'd1);
      read_check("wr_count_1",     TMR_COUNT,  MASK_WORD, 1'b0, 32'd1);
      check_output("wr_irq_masked", {31'd0, irq}, 32'd0);
      write_reg(TMR_STATUS, 32'd1);
      read_check("wr_status_clr", TMR_STATUS, MASK_WORD, 1'b0, 32'd0);

      $display("[TB] sub-word reads and writes");
      do_reset();
      write_reg(TMR_COUNT, 32'h8000_00F0);
      read_check("sb_byte_s",  TMR_COUNT,        MASK_BYTE, 1'b1, 32'hFFFF_FFF0);
      read_check("sb_byte_u",  TMR_COUNT,        MASK_BYTE, 1'b0, 32'h0000_00F0);
      read_check("sb_byte3_s", TMR_COUNT + 5'd3, MASK_BYTE, 1'b1, 32'hFFFF_FF80);
      read_check("sb_half_hi", TMR_COUNT + 5'd2, MASK_HALF, 1'b1, 32'hFFFF_8000);
      read_check("sb_half_lo", TMR_COUNT,        MASK_HALF, 1'b0, 32'h0000_00F0);
      apply_stimulus(1'b1, BASE + 32'(TMR_COUNT), MASK_BYTE, 1'b0, 32'd0);
      @(negedge clk);
      bus.we = 1'b0;
      read_check("sb_write_ignored", TMR_COUNT, MASK_WORD, 1'b0, 32'h8000_00F0);

      $display("[TB] asynchronous reset mid-count");
      do_reset();
      write_reg(TMR_COMPARE, 32'd0);
      write_reg(TMR_CTRL, 32'd5);
      idle(2);
      check_output("ar_irq_before", {31'd0, irq}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check_output("ar_irq_reset", {31'd0, irq}, 32'd0);
      read_check("ar_count_reset",  TMR_COUNT,  MASK_WORD, 1'b0, 32'd0);
      read_check("ar_ctrl_reset",   TMR_CTRL,   MASK_WORD, 1'b0, 32'd0);
      read_check("ar_status_reset", TMR_STATUS, MASK_WORD, 1'b0, 32'd0);
      apply_stimulus(1'b0, BASE + 32'h20, MASK_WORD, 1'b0, 32'd0);
      #1;
      check_output("oob_hit",   {31'd0, bus.hit}, 32'd0);
      check_output("oob_rdata", bus.rdata, 32'd0);
      apply_stimulus(1'b0, BASE + 32'h1C, MASK_WORD, 1'b0, 32'd0);
      #1;
      check_output("rsv_hit",   {31'd0, bus.hit}, 32'd1);
      check_output("rsv_rdata", bus.rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] randomized traffic");
      do_reset();
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         r = $urandom_range(0, 99);
         if (r < 40) begin
            if ($urandom_range(0, 9) == 0) a = BASE + 32'd32 + $urandom_range(0, 64);
            else if ($urandom_range(0, 9) == 0) a = BASE - 32'($urandom_range(1, 8));
            else a = BASE + 32'($urandom_range(0, 31));
            apply_stimulus(1'b0, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 32'd0);
            #1;
            check_output("rnd_rdata", bus.rdata, model_read(bus.addr, bus.mask, bus.signed_ext));
            check_output("rnd_hit", {31'd0, bus.hit}, {31'd0, model_hit(bus.addr)});
         end else if (r < 70) begin
            off = 5'($urandom_range(0, 7) * 4);
            case (off)
               TMR_CTRL:     d = ($urandom() & ~32'd7) | 32'($urandom_range(0, 7));
               TMR_COUNT:    d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20))
                                                             : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
               TMR_COMPARE:  d = 32'($urandom_range(0, 20));
               TMR_STATUS:   d = 32'($urandom_range(0, 1));
               TMR_PRESCALE: d = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
               default:      d = $urandom();
            endcase
            apply_stimulus(1'b1, BASE + 32'(off), ($urandom_range(0, 3) == 0) ? 2'b11 : MASK_WORD, 1'b0, d);
         end else if (r < 80) begin
            apply_stimulus(1'b1, BASE + 32'($urandom_range(0, 31)),
                           ($urandom_range(0, 1) == 1) ? MASK_HALF : MASK_BYTE, 1'b0, $urandom());
         end else begin
            apply_stimulus(1'b0, BASE, MASK_WORD, 1'b0, 32'd0);
         end
         #1;
         check_output("rnd_irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
      end
      bus.we = 1'b0;
      @(negedge clk);
      read_check("rnd_final_count", TMR_COUNT, MASK_WORD, 1'b0, m_count);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
